// File: rtl/wave_gen_dds.sv
// -----------------------------------------------------------------------------
// wave_gen_dds
//
// Direct digital synthesis waveform generator for the DAC data path.
// A phase accumulator advances by a runtime tuning word. A phase offset is
// added to it, and the top ROM_AW bits form the phase index P. Sine, square,
// triangle or sawtooth samples are derived from P, scaled by a gain, and
// presented with a fixed 3-cycle latency from the accumulator value.
//
// Configuration is offered through a valid/ready handshake. It is applied
// immediately when the generator is idle (en low, or tuning word zero).
// Otherwise it waits in a pending register until the next accumulator wrap,
// so a running waveform changes only at a period boundary.
//
// Ports
//   clk, rst     : clock and synchronous active-high reset
//   en           : run enable; low holds the accumulator at zero
//   cfg_valid    : configuration offer
//   cfg_ready    : high when a new configuration can be taken
//   cfg_wave     : 0 sine, 1 square, 2 triangle, 3 sawtooth
//   cfg_ftw      : frequency tuning word
//   cfg_pho      : phase offset added to the accumulator
//   cfg_duty     : square-wave low-time threshold on P
//   cfg_gain     : amplitude gain; sample * (gain+1) / 2^GAIN_W
//   rom_addr     : registered sine ROM address (= P)
//   rom_data     : sine ROM output, valid one cycle after rom_addr
//   data_out     : sample to the DAC, unsigned offset-binary
//   data_valid   : data_out carries a live sample
//   wrap_pulse   : one-cycle pulse after the accumulator wraps
//
// Parameter constraint: DATA_W+2 <= ROM_AW <= ACC_W.
// -----------------------------------------------------------------------------
module wave_gen_dds #(
    parameter int ACC_W  = 24,
    parameter int ROM_AW = 10,
    parameter int DATA_W = 8,
    parameter int GAIN_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [1:0]        cfg_wave,
    input  logic [ACC_W-1:0]  cfg_ftw,
    input  logic [ACC_W-1:0]  cfg_pho,
    input  logic [ROM_AW-1:0] cfg_duty,
    input  logic [GAIN_W-1:0] cfg_gain,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              wrap_pulse
);

    localparam logic [1:0] WAVE_SINE   = 2'd0;
    localparam logic [1:0] WAVE_SQUARE = 2'd1;
    localparam logic [1:0] WAVE_TRI    = 2'd2;
    localparam logic [1:0] WAVE_SAW    = 2'd3;

    localparam int PROD_W = DATA_W + GAIN_W + 1;

    // Reset duty puts the square edge at half period.
    localparam logic [ROM_AW-1:0] DUTY_RST = {1'b1, {(ROM_AW-1){1'b0}}};

    typedef struct packed {
        logic [1:0]        wave;
        logic [ACC_W-1:0]  ftw;
        logic [ACC_W-1:0]  pho;
        logic [ROM_AW-1:0] duty;
        logic [GAIN_W-1:0] gain;
    } cfg_t;

    localparam cfg_t CFG_RST = '{
        wave: WAVE_SINE,
        ftw:  '0,
        pho:  '0,
        duty: DUTY_RST,
        gain: '1
    };

    typedef enum logic {
        CFG_IDLE,
        CFG_PENDING
    } cfg_state_t;

    // -------------------------------------------------------------------------
    // Accumulator and configuration control
    // -------------------------------------------------------------------------
    cfg_state_t        cfg_state_reg, cfg_state_next;
    cfg_t              act_reg, act_next;
    cfg_t              pend_reg, pend_next;
    cfg_t              offer;
    logic [ACC_W-1:0]  acc_reg, acc_next;
    logic [ACC_W:0]    acc_sum;
    logic              wrap_next;
    logic              wrap_pulse_reg;

    assign offer = '{
        wave: cfg_wave,
        ftw:  cfg_ftw,
        pho:  cfg_pho,
        duty: cfg_duty,
        gain: cfg_gain
    };

    always_comb begin
        acc_sum        = {1'b0, acc_reg} + {1'b0, act_reg.ftw};
        acc_next       = en ? acc_sum[ACC_W-1:0] : '0;
        // The carry of this add is the period boundary.
        wrap_next      = en & acc_sum[ACC_W];
        cfg_state_next = cfg_state_reg;
        act_next       = act_reg;
        pend_next      = pend_reg;
        cfg_ready      = 1'b0;

        case (cfg_state_reg)
            CFG_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    // An idle generator has no period to protect, so the
                    // offer takes effect straight away and ready never drops.
                    if (!en || (act_reg.ftw == '0)) begin
                        act_next = offer;
                    end else begin
                        pend_next      = offer;
                        cfg_state_next = CFG_PENDING;
                    end
                end
            end
            CFG_PENDING: begin
                // A wrap on the accept cycle is not seen here (state was
                // still IDLE), so that config waits for the following wrap.
                if (!en || wrap_next) begin
                    act_next       = pend_reg;
                    cfg_state_next = CFG_IDLE;
                end
            end
            default: begin
                cfg_state_next = CFG_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_state_reg  <= CFG_IDLE;
            act_reg        <= CFG_RST;
            pend_reg       <= CFG_RST;
            acc_reg        <= '0;
            wrap_pulse_reg <= 1'b0;
        end else begin
            cfg_state_reg  <= cfg_state_next;
            act_reg        <= act_next;
            pend_reg       <= pend_next;
            acc_reg        <= acc_next;
            wrap_pulse_reg <= wrap_next;
        end
    end

    assign wrap_pulse = wrap_pulse_reg;

    // -------------------------------------------------------------------------
    // Phase index and raw waveform shapes
    // -------------------------------------------------------------------------
    logic [ACC_W-1:0]  phase_sum;
    logic [ROM_AW-1:0] phase;
    logic [DATA_W-1:0] saw_raw;
    logic [DATA_W-1:0] tri_raw;
    logic [DATA_W-1:0] sq_raw;
    logic              unused_phase_lsb;

    assign phase_sum = acc_reg + act_reg.pho;
    assign phase     = phase_sum[ACC_W-1 -: ROM_AW];
    assign saw_raw   = phase[ROM_AW-1 -: DATA_W];
    assign sq_raw    = (phase < act_reg.duty) ? '0 : '1;

    generate
        if (ACC_W > ROM_AW) begin : g_phase_lsb
            assign unused_phase_lsb = ^phase_sum[ACC_W-ROM_AW-1:0];
        end else begin : g_phase_full
            assign unused_phase_lsb = 1'b0;
        end
    endgenerate

    // Triangle: the bits below the MSB ramp up in the first half period and
    // are folded (inverted) in the second half, giving twice the saw slope.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_tri
            assign tri_raw[gi] = phase[ROM_AW-1-DATA_W+gi] ^ phase[ROM_AW-1];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Stage 1: register shapes and the ROM address; wave and gain travel with
    // the sample so a config change never mixes into an in-flight sample.
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] saw_s1_reg;
    logic [DATA_W-1:0] tri_s1_reg;
    logic [DATA_W-1:0] sq_s1_reg;
    logic [ROM_AW-1:0] rom_addr_reg;
    logic [1:0]        wave_s1_reg;
    logic [GAIN_W-1:0] gain_s1_reg;
    logic              valid_s1_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            saw_s1_reg   <= '0;
            tri_s1_reg   <= '0;
            sq_s1_reg    <= '0;
            rom_addr_reg <= '0;
            wave_s1_reg  <= WAVE_SINE;
            gain_s1_reg  <= '1;
            valid_s1_reg <= 1'b0;
        end else begin
            saw_s1_reg   <= saw_raw;
            tri_s1_reg   <= tri_raw;
            sq_s1_reg    <= sq_raw;
            rom_addr_reg <= phase;
            wave_s1_reg  <= act_reg.wave;
            gain_s1_reg  <= act_reg.gain;
            valid_s1_reg <= en;
        end
    end

    assign rom_addr = rom_addr_reg;

    // -------------------------------------------------------------------------
    // Stage 2: select the computed shape. The ROM is reading during this
    // stage, so sine is only flagged here and its data is taken in stage 3.
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] raw_s2_next;
    logic [DATA_W-1:0] raw_s2_reg;
    logic              sine_s2_reg;
    logic [GAIN_W-1:0] gain_s2_reg;
    logic              valid_s2_reg;

    always_comb begin
        raw_s2_next = '0;
        case (wave_s1_reg)
            WAVE_SQUARE: raw_s2_next = sq_s1_reg;
            WAVE_TRI:    raw_s2_next = tri_s1_reg;
            WAVE_SAW:    raw_s2_next = saw_s1_reg;
            default:     raw_s2_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            raw_s2_reg   <= '0;
            sine_s2_reg  <= 1'b0;
            gain_s2_reg  <= '1;
            valid_s2_reg <= 1'b0;
        end else begin
            raw_s2_reg   <= raw_s2_next;
            sine_s2_reg  <= (wave_s1_reg == WAVE_SINE);
            gain_s2_reg  <= gain_s1_reg;
            valid_s2_reg <= valid_s1_reg;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 3: gain scaling. raw*(gain+1) < 2^(DATA_W+GAIN_W), so the shifted
    // product always fits DATA_W bits and gain=all-ones returns raw exactly.
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] raw_s3;
    logic [GAIN_W:0]   gain_p1;
    logic [PROD_W-1:0] prod;
    logic [DATA_W-1:0] scaled;
    logic              unused_prod_bits;
    logic [DATA_W-1:0] data_out_reg;
    logic              data_valid_reg;

    assign raw_s3           = sine_s2_reg ? rom_data : raw_s2_reg;
    assign gain_p1          = {1'b0, gain_s2_reg} + {{GAIN_W{1'b0}}, 1'b1};
    assign prod             = PROD_W'(raw_s3) * PROD_W'(gain_p1);
    assign scaled           = prod[GAIN_W +: DATA_W];
    assign unused_prod_bits = ^{prod[PROD_W-1], prod[GAIN_W-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
        end else begin
            data_out_reg   <= valid_s2_reg ? scaled : '0;
            data_valid_reg <= valid_s2_reg;
        end
    end

    assign data_out   = data_out_reg;
    assign data_valid = data_valid_reg;

endmodule

// File: tb/tb_wave_gen_dds.sv
// -----------------------------------------------------------------------------
// Testbench for wave_gen_dds (ACC_W=16, ROM_AW=10, DATA_W=8, GAIN_W=8).
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// A step of j cycles after en rises shows the sample for accumulator index
// k = j-3, where acc(k) = k*ftw mod 2^16.
// -----------------------------------------------------------------------------
module tb_wave_gen_dds;
    localparam int ACC_W  = 16;
    localparam int ROM_AW = 10;
    localparam int DATA_W = 8;
    localparam int GAIN_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [1:0]        cfg_wave;
    logic [ACC_W-1:0]  cfg_ftw;
    logic [ACC_W-1:0]  cfg_pho;
    logic [ROM_AW-1:0] cfg_duty;
    logic [GAIN_W-1:0] cfg_gain;
    logic [ROM_AW-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              wrap_pulse;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wave_gen_dds #(
        .ACC_W (ACC_W),
        .ROM_AW(ROM_AW),
        .DATA_W(DATA_W),
        .GAIN_W(GAIN_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_wave  (cfg_wave),
        .cfg_ftw   (cfg_ftw),
        .cfg_pho   (cfg_pho),
        .cfg_duty  (cfg_duty),
        .cfg_gain  (cfg_gain),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .data_out  (data_out),
        .data_valid(data_valid),
        .wrap_pulse(wrap_pulse)
    );

    // Stand-in sine ROM: one-cycle latency, returns addr[9:2].
    logic unused_rom_lsb;
    assign unused_rom_lsb = ^rom_addr[1:0];
    always @(posedge clk) rom_data <= rom_addr[9:2];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: phase index for accumulator index k.
    function automatic int phase_idx(longint k, longint ftw, longint pho);
        return int'(((k * ftw + pho) % 65536) / 64);
    endfunction

    // Reference: scaled sample from a phase index.
    function automatic int model_sample(int wave, int p, int duty, int gain);
        int raw;
        case (wave)
            1:       raw = (p < duty) ? 0 : 255;
            2:       raw = (p < 512) ? (p / 2) : (255 - (p - 512) / 2);
            default: raw = p / 4;   // saw, and sine through the addr[9:2] ROM
        endcase
        return (raw * (gain + 1)) / 256;
    endfunction

    task automatic start_run(input logic [1:0] w, input logic [15:0] f,
                             input logic [15:0] p, input logic [9:0] d,
                             input logic [7:0] g);
        en        = 1'b0;
        cfg_valid = 1'b0;
        step();
        cfg_wave  = w;
        cfg_ftw   = f;
        cfg_pho   = p;
        cfg_duty  = d;
        cfg_gain  = g;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        en        = 1'b1;
    endtask

    task automatic stop_run();
        en        = 1'b0;
        cfg_valid = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0;
        cfg_wave = 2'd0; cfg_ftw = '0; cfg_pho = '0; cfg_duty = '0; cfg_gain = '0;
        step();
        step();
        checks++; if (data_out !== 8'd0) begin failures++; $display("FAIL reset_data_out got %0d want 0", data_out); end
        checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL reset_data_valid got %0b want 0", data_valid); end
        checks++; if (wrap_pulse !== 1'b0) begin failures++; $display("FAIL reset_wrap got %0b want 0", wrap_pulse); end
        checks++; if (rom_addr !== 10'd0) begin failures++; $display("FAIL reset_rom_addr got %0d want 0", rom_addr); end
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_cfg_ready got %0b want 1", cfg_ready); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_saw();
        logic [7:0] exp_d;
        start_run(2'd3, 16'h0100, 16'h0000, 10'd512, 8'hFF);
        for (int j = 1; j <= 515; j++) begin
            step();
            checks++; if (data_valid !== (j >= 3)) begin failures++; $display("FAIL saw_valid step %0d got %0b want %0b", j, data_valid, (j >= 3)); end
            exp_d = (j >= 3) ? 8'((j - 3) % 256) : 8'd0;
            checks++; if (data_out !== exp_d) begin failures++; $display("FAIL saw_data step %0d got %0d want %0d", j, data_out, exp_d); end
            checks++; if (wrap_pulse !== (j % 256 == 0)) begin failures++; $display("FAIL saw_wrap step %0d got %0b want %0b", j, wrap_pulse, (j % 256 == 0)); end
        end
        // Falling en: two more valid samples drain, then valid low and data 0.
        en = 1'b0;
        for (int d = 1; d <= 4; d++) begin
            step();
            checks++; if (data_valid !== (d < 3)) begin failures++; $display("FAIL drain_valid step %0d got %0b want %0b", d, data_valid, (d < 3)); end
            exp_d = (d < 3) ? 8'((512 + d) % 256) : 8'd0;
            checks++; if (data_out !== exp_d) begin failures++; $display("FAIL drain_data step %0d got %0d want %0d", d, data_out, exp_d); end
        end
    endtask

    task automatic test_square();
        logic [7:0] exp_d;
        start_run(2'd1, 16'h0100, 16'h0000, 10'd256, 8'hFF);
        for (int j = 3; j <= 3 + 300; j++) begin
            if (j == 3) begin step(); step(); end
            step();
            exp_d = (((j - 3) % 256) < 64) ? 8'd0 : 8'd255;
            checks++; if (data_out !== exp_d) begin failures++; $display("FAIL square_data step %0d got %0d want %0d", j, data_out, exp_d); end
        end
        stop_run();
    endtask

    task automatic test_triangle();
        int m;
        logic [7:0] exp_d;
        start_run(2'd2, 16'h0100, 16'h0000, 10'd512, 8'hFF);
        step(); step();
        for (int j = 3; j <= 3 + 300; j++) begin
            step();
            m = (j - 3) % 256;
            exp_d = (m < 128) ? 8'(2 * m) : 8'(255 - 2 * (m - 128));
            checks++; if (data_out !== exp_d) begin failures++; $display("FAIL tri_data step %0d got %0d want %0d", j, data_out, exp_d); end
        end
        stop_run();
    endtask

    task automatic test_sine();
        logic [9:0] exp_a;
        logic [7:0] exp_d;
        start_run(2'd0, 16'h0100, 16'h0000, 10'd512, 8'hFF);
        for (int j = 1; j <= 270; j++) begin
            step();
            exp_a = 10'(4 * ((j - 1) % 256));
            checks++; if (rom_addr !== exp_a) begin failures++; $display("FAIL sine_addr step %0d got %0d want %0d", j, rom_addr, exp_a); end
            if (j >= 3) begin
                exp_d = 8'((j - 3) % 256);
                checks++; if (data_out !== exp_d) begin failures++; $display("FAIL sine_data step %0d got %0d want %0d", j, data_out, exp_d); end
            end
        end
        stop_run();
    endtask

    task automatic test_gain_offset();
        logic [7:0] exp_d;
        start_run(2'd3, 16'h0100, 16'h0000, 10'd512, 8'h7F);
        step(); step();
        for (int j = 3; j <= 260; j++) begin
            step();
            exp_d = 8'(((j - 3) % 256) / 2);
            checks++; if (data_out !== exp_d) begin failures++; $display("FAIL gain_data step %0d got %0d want %0d", j, data_out, exp_d); end
            if (j == 203) begin
                checks++; if (data_out !== 8'd100) begin failures++; $display("FAIL gain_raw200 got %0d want 100", data_out); end
            end
        end
        stop_run();
        start_run(2'd3, 16'h0100, 16'h8000, 10'd512, 8'hFF);
        step(); step();
        for (int j = 3; j <= 260; j++) begin
            step();
            exp_d = 8'(((j - 3) + 128) % 256);
            checks++; if (data_out !== exp_d) begin failures++; $display("FAIL pho_data step %0d got %0d want %0d", j, data_out, exp_d); end
        end
        stop_run();
    endtask

    task automatic test_handshake();
        int k;
        int ph;
        logic exp_r;
        logic exp_w;
        logic [7:0] exp_d;
        start_run(2'd3, 16'h0100, 16'h0000, 10'd512, 8'hFF);
        for (int j = 1; j <= 450; j++) begin
            // First offer mid-period; second offer held while the first is pending.
            cfg_valid = (j == 101) || (j >= 151 && j <= 257);
            cfg_ftw   = (j == 101) ? 16'h0200 : 16'h0300;
            step();
            exp_r = !((j >= 101 && j <= 255) || (j >= 257 && j <= 383));
            checks++; if (cfg_ready !== exp_r) begin failures++; $display("FAIL hs_ready step %0d got %0b want %0b", j, cfg_ready, exp_r); end
            if (j <= 384) begin
                exp_w = (j == 256) || (j == 384);
                checks++; if (wrap_pulse !== exp_w) begin failures++; $display("FAIL hs_wrap step %0d got %0b want %0b", j, wrap_pulse, exp_w); end
            end
            if (j >= 3) begin
                k = j - 3;
                if (k < 256)      ph = k * 256;
                else if (k < 384) ph = (k - 256) * 512;
                else              ph = ((k - 384) * 768) % 65536;
                exp_d = 8'(ph / 256);
                checks++; if (data_out !== exp_d) begin failures++; $display("FAIL hs_data step %0d got %0d want %0d", j, data_out, exp_d); end
            end
        end
        stop_run();
    endtask

    task automatic test_random();
        logic [1:0] w;
        logic [15:0] f;
        logic [15:0] p;
        logic [9:0] d;
        logic [7:0] g;
        logic [7:0] exp_d;
        logic [9:0] exp_a;
        logic exp_w;
        for (int it = 0; it < 10; it++) begin
            w = 2'($urandom_range(0, 3));
            f = 16'($urandom_range(1, 65535));
            p = 16'($urandom);
            d = 10'($urandom_range(0, 1023));
            g = 8'($urandom_range(0, 255));
            if (it == 0) begin w = 2'd1; d = 10'd0; end   // duty 0: constant max
            start_run(w, f, p, d, g);
            checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL rnd_ready_en0 iter %0d got %0b want 1", it, cfg_ready); end
            for (int j = 1; j <= 40; j++) begin
                step();
                exp_a = 10'(phase_idx(j - 1, f, p));
                checks++; if (rom_addr !== exp_a) begin failures++; $display("FAIL rnd_addr iter %0d step %0d got %0d want %0d", it, j, rom_addr, exp_a); end
                exp_w = ((j * int'(f)) / 65536) != (((j - 1) * int'(f)) / 65536);
                checks++; if (wrap_pulse !== exp_w) begin failures++; $display("FAIL rnd_wrap iter %0d step %0d got %0b want %0b", it, j, wrap_pulse, exp_w); end
                checks++; if (data_valid !== (j >= 3)) begin failures++; $display("FAIL rnd_valid iter %0d step %0d got %0b", it, j, data_valid); end
                exp_d = (j >= 3) ? 8'(model_sample(int'(w), phase_idx(j - 3, f, p), int'(d), int'(g))) : 8'd0;
                checks++; if (data_out !== exp_d) begin failures++; $display("FAIL rnd_data iter %0d wave %0d step %0d got %0d want %0d", it, w, j, data_out, exp_d); end
            end
            stop_run();
        end
    endtask

    task automatic test_reset_mid_run();
        start_run(2'd3, 16'h0100, 16'h0000, 10'd512, 8'hFF);
        repeat (50) step();
        cfg_ftw   = 16'h0200;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL rst_pending_ready got %0b want 0", cfg_ready); end
        rst = 1'b1;
        en  = 1'b0;
        step();
        checks++; if (data_out !== 8'd0) begin failures++; $display("FAIL rst_mid_data got %0d want 0", data_out); end
        checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got %0b want 0", data_valid); end
        checks++; if (wrap_pulse !== 1'b0) begin failures++; $display("FAIL rst_mid_wrap got %0b want 0", wrap_pulse); end
        checks++; if (rom_addr !== 10'd0) begin failures++; $display("FAIL rst_mid_addr got %0d want 0", rom_addr); end
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got %0b want 1", cfg_ready); end
        rst = 1'b0;
        en  = 1'b1;
        // Default config has ftw=0 and pho=0: phase stays at 0, nothing pending.
        for (int j = 1; j <= 6; j++) begin
            step();
            checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL rst_discard_ready step %0d got %0b want 1", j, cfg_ready); end
            checks++; if (rom_addr !== 10'd0) begin failures++; $display("FAIL rst_default_addr step %0d got %0d want 0", j, rom_addr); end
            checks++; if (data_valid !== (j >= 3)) begin failures++; $display("FAIL rst_default_valid step %0d got %0b", j, data_valid); end
        end
        stop_run();
    endtask

    initial begin
        test_reset();
        test_saw();
        test_square();
        test_triangle();
        test_sine();
        test_gain_offset();
        test_handshake();
        test_random();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wave_gen_dds.md
Name: wave_gen_dds

Overview:
- Parametrised DDS multi-waveform generator feeding the DAC data path. Replaces fixed-step counter generators.
- Uses a phase accumulator with runtime tuning word, phase offset, duty and gain, and generates sine, square, triangle or sawtooth.
- Configuration arrives through a valid/ready handshake and is applied glitch-free at a period boundary.
- Sine samples come from an external full-wave ROM with 1-cycle read latency.

Parameters:
- ACC_W, 24: phase accumulator width.
- ROM_AW, 10: phase index width (PH_W) and sine ROM address width. Must satisfy DATA_W+2 <= ROM_AW <= ACC_W.
- DATA_W, 8: sample width, unsigned offset-binary.
- GAIN_W, 8: amplitude gain width.

Ports:
- clk, in, 1: sole clock.
- rst, in, 1: synchronous, active-high reset.
- en, in, 1: run enable.
- cfg_valid, in, 1: config offer.
- cfg_ready, out, 1: config accepted when cfg_valid && cfg_ready.
- cfg_wave, in, 2: waveform select. 0 sine, 1 square, 2 triangle, 3 saw.
- cfg_ftw, in, ACC_W: frequency tuning word.
- cfg_pho, in, ACC_W: phase offset.
- cfg_duty, in, ROM_AW: square low-time threshold.
- cfg_gain, in, GAIN_W: amplitude gain.
- rom_addr, out, ROM_AW: sine ROM address (registered).
- rom_data, in, DATA_W: ROM output, valid 1 cycle after rom_addr.
- data_out, out, DATA_W: sample to DAC.
- data_valid, out, 1: data_out is live.
- wrap_pulse, out, 1: 1-cycle pulse on accumulator wrap.

Behaviour:
- Reset values:
  - acc=0, rom_addr=0, data_out=0, data_valid=0, wrap_pulse=0, cfg_ready=1.
  - Active config: wave=0, ftw=0, pho=0, duty=2^(ROM_AW-1), gain=all-ones. No pending config.
- Accumulator:
  - en=1: acc <= acc+ftw, mod 2^ACC_W. The carry-out sets wrap_pulse next cycle.
  - en=0: acc <= 0.
- Phase index: P = top ROM_AW bits of (acc+pho), mod 2^ACC_W.
- Raw sample, all computed from the same P:
  - Saw: P[ROM_AW-1 -: DATA_W].
  - Triangle: P[ROM_AW-2 -: DATA_W] when P MSB is 0, else bitwise inverse of it.
  - Square: 0 if P<duty, else 2^DATA_W-1. duty=0 gives constant max.
  - Sine: rom_addr <= P; rom_data is used one cycle later.
- Pipeline:
  - Stage 1: register P-derived raw values and rom_addr.
  - Stage 2: select the raw sample by the wave value delayed to match.
  - Stage 3: data_out <= (raw*(gain+1)) >> GAIN_W. Full-width product, no overflow; gain=all-ones returns raw.
  - Latency is fixed at 3 cycles: data_out at n+3 reflects acc at n, for every waveform.
- data_valid = en delayed 3 cycles. data_out is forced to 0 when its stage has data_valid=0.
- Config handshake:
  - Accept while cfg_ready=1. The accepted fields go into a pending register and cfg_ready drops.
  - Apply immediately (next cycle) if en=0 or active ftw=0; cfg_ready returns to 1 the same cycle.
  - Otherwise apply on the cycle the accumulator wraps. The new ftw is used from the following add; cfg_ready rises that cycle.
  - If accept and wrap occur in the same cycle, the new config stays pending until the next wrap.
  - Config fields travel down the pipeline with their samples, so there are no mixed-config samples.
- en edges:
  - Rising: acc starts from 0; the first valid sample is at phase pho.
  - Falling: the pipeline drains with valid low after 3 cycles. Pending config applies.
- rst mid-operation: every state returns to reset values next cycle and the pending config is discarded.

Test Plan (ACC_W=16, ROM_AW=10, DATA_W=8, GAIN_W=8):
- Saw, ftw=0x0100, gain=0xFF, en high:
  - data_out counts 0,1,2..255 from cycle 3 after en, repeating.
  - wrap_pulse every 256 cycles; data_valid rises exactly 3 cycles after en.
- Square, duty=256, same ftw: per 256-cycle period, 64 samples of 0 then 192 samples of 255.
- Triangle, same ftw: samples 0,2,4..254, then 255,253..1, period 256.
- Sine, same ftw: rom_addr steps 0,4,8..; the bench ROM returns addr[9:2]; data_out equals that value 2 cycles after the address.
- Gain/offset:
  - gain=0x7F on saw: raw 200 appears as 100.
  - pho=0x8000: saw starts at 128.
- Handshake:
  - Offer ftw=0x0200 mid-period: cfg_ready low until the wrap, then the slope doubles from the next sample.
  - Second offer while pending: stalls.
  - Offer with en=0: cfg_ready stays 1.
  - rst asserted mid-run: all outputs 0 next cycle.
